// File: rtl/alu_arbiter_if.sv
// Request/response handshake bundle between the two ALU requesters (fetch/branch, execute)
// and alu_arbiter. The master side is the requester pair; the slave side is the arbiter.
interface alu_arbiter_if #(
  parameter int DW = 32
);
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_opA, req0_opB, req1_opA, req1_opB;
  logic [4:0]    req0_op, req0_shamt, req1_op, req1_shamt;
  logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DW-1:0] rsp0_result, rsp1_result;
  logic          rsp0_ne, rsp0_lt, rsp0_ovf, rsp1_ne, rsp1_lt, rsp1_ovf;

  modport master (
    output req0_valid, req0_opA, req0_opB, req0_op, req0_shamt,
    output req1_valid, req1_opA, req1_opB, req1_op, req1_shamt,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_ne, rsp0_lt, rsp0_ovf,
    input  rsp1_valid, rsp1_result, rsp1_ne, rsp1_lt, rsp1_ovf,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_opA, req0_opB, req0_op, req0_shamt,
    input  req1_valid, req1_opA, req1_opB, req1_op, req1_shamt,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_ne, rsp0_lt, rsp0_ovf,
    output rsp1_valid, rsp1_result, rsp1_ne, rsp1_lt, rsp1_ovf,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational alu between two requesters, one operation in flight (IDLE->EXEC->RESP).
// Define ALU_ARB_STATS_EN to enable the saturating per-requester grant counters.
module alu_arbiter #(
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clock,
  input  logic            reset,
  alu_arbiter_if.slave    bus,
  output logic [DW-1:0]   alu_opA,
  output logic [DW-1:0]   alu_opB,
  output logic [4:0]      alu_op,
  output logic [4:0]      alu_shamt,
  input  logic [DW-1:0]   alu_result,
  input  logic            alu_ne,
  input  logic            alu_lt,
  input  logic            alu_ovf,
  output logic [CNTW-1:0] grant_cnt0,
  output logic [CNTW-1:0] grant_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state;
  logic          last_grant;
  logic          owner;
  logic [1:0]    acc;
  logic [1:0]    rsp_vld;
  logic [DW-1:0] res_q;
  logic          ne_q, lt_q, ovf_q;

  // On a tie the requester that did not win last goes first.
  always_comb begin
    acc    = 2'b00;
    acc[0] = (state == IDLE) && bus.req0_valid && (!bus.req1_valid || last_grant);
    acc[1] = (state == IDLE) && bus.req1_valid && (!bus.req0_valid || !last_grant);
  end

  assign bus.req0_ready = acc[0];
  assign bus.req1_ready = acc[1];

  // The alu_* outputs double as the operand registers, so they hold between operations.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_op     <= '0;
      alu_shamt  <= '0;
      res_q      <= '0;
      ne_q       <= 1'b0;
      lt_q       <= 1'b0;
      ovf_q      <= 1'b0;
      rsp_vld    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (|acc) begin
            alu_opA    <= acc[1] ? bus.req1_opA   : bus.req0_opA;
            alu_opB    <= acc[1] ? bus.req1_opB   : bus.req0_opB;
            alu_op     <= acc[1] ? bus.req1_op    : bus.req0_op;
            alu_shamt  <= acc[1] ? bus.req1_shamt : bus.req0_shamt;
            owner      <= acc[1];
            last_grant <= acc[1];
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_q   <= alu_result;
          ne_q    <= alu_ne;
          lt_q    <= alu_lt;
          ovf_q   <= alu_ovf;
          rsp_vld <= owner ? 2'b10 : 2'b01;
          state   <= RESP;
        end
        RESP: begin
          if (|(rsp_vld & {bus.rsp1_ready, bus.rsp0_ready})) begin
            rsp_vld <= 2'b00;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rsp0_valid  = rsp_vld[0];
  assign bus.rsp1_valid  = rsp_vld[1];
  assign bus.rsp0_result = res_q;
  assign bus.rsp1_result = res_q;
  assign bus.rsp0_ne     = ne_q;
  assign bus.rsp1_ne     = ne_q;
  assign bus.rsp0_lt     = lt_q;
  assign bus.rsp1_lt     = lt_q;
  assign bus.rsp0_ovf    = ovf_q;
  assign bus.rsp1_ovf    = ovf_q;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (acc[0] && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + CNTW'(1);
      if (acc[1] && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + CNTW'(1);
    end
  end
`else
  assign grant_cnt0 = '0;
  assign grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized + directed bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;
  localparam int DW   = 32;
  localparam int CNTW = 16;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          ne;
    logic          lt;
    logic          ovf;
  } alu_out_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_arbiter_if #(.DW(DW)) bus ();

  logic [DW-1:0]   alu_opA, alu_opB, alu_result;
  logic [4:0]      alu_op, alu_shamt;
  logic            alu_ne, alu_lt, alu_ovf;
  logic [CNTW-1:0] grant_cnt0, grant_cnt1;

  alu_arbiter #(.DW(DW), .CNTW(CNTW)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_op     (alu_op),
    .alu_shamt  (alu_shamt),
    .alu_result (alu_result),
    .alu_ne     (alu_ne),
    .alu_lt     (alu_lt),
    .alu_ovf    (alu_ovf),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  // Behavioural alu: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra.
  function automatic alu_out_t ref_alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                       input logic [4:0] op, input logic [4:0] sh);
    alu_out_t o;
    logic [DW-1:0] d;
    d     = a - b;
    o.ne  = (a != b);
    o.lt  = ($signed(a) < $signed(b));
    o.ovf = 1'b0;
    case (op)
      5'd0: begin
        o.res = a + b;
        o.ovf = (a[DW-1] == b[DW-1]) && (o.res[DW-1] != a[DW-1]);
      end
      5'd1: begin
        o.res = d;
        o.ovf = (a[DW-1] != b[DW-1]) && (d[DW-1] != a[DW-1]);
      end
      5'd2:    o.res = a & b;
      5'd3:    o.res = a | b;
      5'd4:    o.res = a << sh;
      5'd5:    o.res = DW'($signed(a) >>> sh);
      default: o.res = '0;
    endcase
    return o;
  endfunction

  alu_out_t alu_out;
  always_comb alu_out = ref_alu(alu_opA, alu_opB, alu_op, alu_shamt);
  assign alu_result = alu_out.res;
  assign alu_ne     = alu_out.ne;
  assign alu_lt     = alu_out.lt;
  assign alu_ovf    = alu_out.ovf;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, tracked by its age in cycles since acceptance.
  logic          m_busy, m_own, m_last;
  int            m_age, m_cnt0, m_cnt1;
  logic [DW-1:0] m_a, m_b;
  logic [4:0]    m_op, m_sh;
  alu_out_t      m_exp;

  always @(negedge clock) begin : model
    logic v0, v1, win, e0, e1, in_rsp, orny;
    int c0, c1;
    if (reset) begin
      m_busy = 1'b0; m_own = 1'b0; m_last = 1'b1; m_age = 0;
      m_cnt0 = 0; m_cnt1 = 0;
      m_a = '0; m_b = '0; m_op = '0; m_sh = '0; m_exp = '0;
    end else begin
      v0  = bus.req0_valid;
      v1  = bus.req1_valid;
      win = (v0 && v1) ? !m_last : v1;
      e0  = !m_busy && (v0 || v1) && !win;
      e1  = !m_busy && (v0 || v1) && win;
      chk("req0_ready", bus.req0_ready, e0);
      chk("req1_ready", bus.req1_ready, e1);
      in_rsp = m_busy && (m_age >= 2);
      chk("rsp0_valid", bus.rsp0_valid, in_rsp && !m_own);
      chk("rsp1_valid", bus.rsp1_valid, in_rsp && m_own);
      if (in_rsp) begin
        chk("rsp0_fields", {bus.rsp0_result, bus.rsp0_ne, bus.rsp0_lt, bus.rsp0_ovf}, m_exp);
        chk("rsp1_fields", {bus.rsp1_result, bus.rsp1_ne, bus.rsp1_lt, bus.rsp1_ovf}, m_exp);
      end
      chk("alu_opA", alu_opA, m_a);
      chk("alu_opB_op_sh", {alu_opB, alu_op, alu_shamt}, {m_b, m_op, m_sh});
`ifdef ALU_ARB_STATS_EN
      c0 = m_cnt0; c1 = m_cnt1;
`else
      c0 = 0; c1 = 0;
`endif
      chk("grant_cnt0", grant_cnt0, c0);
      chk("grant_cnt1", grant_cnt1, c1);
      if (m_busy) begin
        orny = m_own ? bus.rsp1_ready : bus.rsp0_ready;
        if (in_rsp && orny) m_busy = 1'b0;
        else m_age++;
      end else if (e0 || e1) begin
        m_busy = 1'b1;
        m_age  = 1;
        m_own  = e1;
        m_last = e1;
        m_a    = e1 ? bus.req1_opA   : bus.req0_opA;
        m_b    = e1 ? bus.req1_opB   : bus.req0_opB;
        m_op   = e1 ? bus.req1_op    : bus.req0_op;
        m_sh   = e1 ? bus.req1_shamt : bus.req0_shamt;
        m_exp  = ref_alu(m_a, m_b, m_op, m_sh);
        if (e1) m_cnt1 = (m_cnt1 < (1 << CNTW) - 1) ? m_cnt1 + 1 : m_cnt1;
        else    m_cnt0 = (m_cnt0 < (1 << CNTW) - 1) ? m_cnt0 + 1 : m_cnt0;
      end
    end
  end

  task automatic set_req(input int who, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] op, input logic [4:0] sh);
    if (who == 1) begin
      bus.req1_opA = a; bus.req1_opB = b; bus.req1_op = op; bus.req1_shamt = sh;
      bus.req1_valid = 1'b1;
    end else begin
      bus.req0_opA = a; bus.req0_opB = b; bus.req0_op = op; bus.req0_shamt = sh;
      bus.req0_valid = 1'b1;
    end
  endtask

  task automatic rand_req(input int who);
    logic [DW-1:0] a, b;
    a = $urandom;
    b = $urandom;
    case ($urandom_range(3))
      0: b = a;
      1: begin a = 32'h7FFF_FFFF; b = $urandom_range(3); end
      2: begin a = 32'h8000_0000; b = $urandom_range(3); end
      default: ;
    endcase
    set_req(who, a, b, 5'($urandom_range(5)), 5'($urandom_range(31)));
  endtask

  // Returns at posedge+2 of the accept edge with the request withdrawn.
  task automatic wait_acc(input int who, output int n);
    logic hit;
    hit = 1'b0;
    n   = 0;
    while (!hit && n < 50) begin
      @(negedge clock);
      n++;
      hit = (who == 1) ? (bus.req1_valid && bus.req1_ready) : (bus.req0_valid && bus.req0_ready);
    end
    if (!hit) chk("accept_timeout", 0, 1);
    @(posedge clock); #2;
    if (who == 1) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int who, output alu_out_t r);
    logic hit;
    int n;
    hit = 1'b0;
    n   = 0;
    r   = '0;
    while (!hit && n < 50) begin
      @(negedge clock);
      n++;
      hit = (who == 1) ? bus.rsp1_valid : bus.rsp0_valid;
    end
    if (!hit) chk("rsp_timeout", 0, 1);
    r = (who == 1) ? {bus.rsp1_result, bus.rsp1_ne, bus.rsp1_lt, bus.rsp1_ovf}
                   : {bus.rsp0_result, bus.rsp0_ne, bus.rsp0_lt, bus.rsp0_ovf};
    @(posedge clock); #2;
  endtask

  task automatic reset_dut();
    @(posedge clock); #2;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (2) @(posedge clock);
    #2 reset = 1'b0;
  endtask

  task automatic drain();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (6) @(posedge clock);
    #2;
  endtask

  task automatic rand_phase(input int cycles);
    logic a0, a1;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clock); #2;
      if (a0 || !bus.req0_valid) begin
        if ($urandom_range(99) < 40) rand_req(0); else bus.req0_valid = 1'b0;
      end else if ($urandom_range(99) < 5) bus.req0_valid = 1'b0;
      if (a1 || !bus.req1_valid) begin
        if ($urandom_range(99) < 40) rand_req(1); else bus.req1_valid = 1'b0;
      end else if ($urandom_range(99) < 5) bus.req1_valid = 1'b0;
      bus.rsp0_ready = ($urandom_range(99) < 60);
      bus.rsp1_ready = ($urandom_range(99) < 60);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_out_t r;
    int n, prev, exp_c0;
    logic a0, a1, hit;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_opA = '0; bus.req0_opB = '0; bus.req0_op = '0; bus.req0_shamt = '0;
    bus.req1_opA = '0; bus.req1_opB = '0; bus.req1_op = '0; bus.req1_shamt = '0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

    // reset state
    #12;
    chk("rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("rst_alu_out", {alu_opA, alu_opB, alu_op, alu_shamt}, 0);
    chk("rst_cnt", {grant_cnt0, grant_cnt1}, 0);
    chk("rst_rsp_result", bus.rsp0_result, 0);
    @(posedge clock); #2 reset = 1'b0;

    // single req0: 5 + 7
    set_req(0, 32'd5, 32'd7, 5'd0, 5'd0);
    wait_acc(0, n);
    wait_rsp(0, r);
    chk("single_result", r.res, 32'd12);
    chk("single_ovf", r.ovf, 0);

    // simultaneous after reset: req0 wins the first tie
    reset_dut();
    set_req(0, 32'hF0, 32'h3C, 5'd2, 5'd0);
    set_req(1, 32'd3, 32'd9, 5'd1, 5'd0);
    wait_acc(0, n);
    wait_rsp(0, r);
    chk("tie_and_result", r.res, 32'h30);
    wait_acc(1, n);
    wait_rsp(1, r);
    chk("tie_sub_result", r.res, 32'hFFFF_FFFA);
    chk("tie_sub_flags", {r.ne, r.lt, r.ovf}, 3'b110);

    // sustained tie: alternating grants, 3 cycles apart
    reset_dut();
    rand_req(0);
    rand_req(1);
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      hit = 1'b0; n = 0; a0 = 1'b0; a1 = 1'b0;
      while (!hit && n < 20) begin
        @(negedge clock);
        n++;
        a0 = bus.req0_valid && bus.req0_ready;
        a1 = bus.req1_valid && bus.req1_ready;
        hit = a0 || a1;
      end
      if (!hit) chk("tie_timeout", 0, 1);
      chk("tie_order", a1, k % 2);
      if (k > 0) chk("tie_gap", cyc - prev, 3);
      prev = cyc;
      @(posedge clock); #2;
      rand_req(a1 ? 1 : 0);
    end
    drain();

    // signed overflow on add from req1
    set_req(1, 32'h7FFF_FFFF, 32'd1, 5'd0, 5'd0);
    wait_acc(1, n);
    wait_rsp(1, r);
    chk("ovf_result", r.res, 32'h8000_0000);
    chk("ovf_flag", r.ovf, 1);

    // backpressure on rsp0 while req1 waits
    bus.rsp0_ready = 1'b0;
    set_req(0, 32'd20, 32'd20, 5'd1, 5'd0);
    wait_acc(0, n);
    set_req(1, 32'd100, 32'd42, 5'd1, 5'd0);
    wait_rsp(0, r);
    chk("bp_result", r, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_req1_ready", bus.req1_ready, 0);
      chk("bp_rsp0_hold", {bus.rsp0_valid, bus.rsp0_result, bus.rsp0_ne, bus.rsp0_lt, bus.rsp0_ovf},
          {1'b1, r});
    end
    @(posedge clock); #2 bus.rsp0_ready = 1'b1;
    @(negedge clock);
    chk("bp_handshake_req1_ready", bus.req1_ready, 0);
    @(negedge clock);
    chk("bp_after_req1_ready", bus.req1_ready, 1);
    @(posedge clock); #2 bus.req1_valid = 1'b0;
    wait_rsp(1, r);
    chk("bp_req1_result", r.res, 32'd58);

    // reset while in EXEC discards the transaction
    set_req(0, 32'd1, 32'd2, 5'd0, 5'd0);
    wait_acc(0, n);
    reset = 1'b1;
    #1;
    chk("exec_rst_rsp_valid", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    chk("exec_rst_cnt", {grant_cnt0, grant_cnt1}, 0);
    chk("exec_rst_alu", {alu_opA, alu_opB, alu_op}, 0);
    @(posedge clock); #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rand_req(0);
      wait_acc(0, n);
      if (k == 0) chk("exec_rst_idle", n, 1);
      wait_rsp(0, r);
    end
`ifdef ALU_ARB_STATS_EN
    exp_c0 = 3;
`else
    exp_c0 = 0;
`endif
    chk("cnt0_after_3", grant_cnt0, exp_c0);
    chk("cnt1_after_3", grant_cnt1, 0);

    // randomized traffic
    reset_dut();
    rand_phase(400);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
